uwarm_instr_encoder: RTL

Sequential instruction encoder for the single-cycle UWARM core. It is the inverse of the core's instruction decode. It accepts one symbolic instruction per handshake (mnemonic, condition, registers, immediates) and emits the 32-bit ARM machine word with its instruction-memory byte address. Words leave through a 2-entry ready/valid output queue toward the instruction-memory loader; the test harness uses this path to build programs.

---
 rtl/uwarm_instr_encoder.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/uwarm_instr_encoder.sv
// Symbolic-to-ARM instruction encoder feeding a 2-entry ready/valid queue toward the IMEM loader.
// Define UWARM_ENC_HALT_EN to add the HALT mnemonic (branch-to-self) and the halted output.
module uwarm_instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          COUNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         in_mnem,
    input  logic [3:0]         in_cond,
    input  logic               in_s,
    input  logic               in_imm,
    input  logic [3:0]         in_rd,
    input  logic [3:0]         in_rn,
    input  logic [3:0]         in_rm,
    input  logic [11:0]        in_imm12,
    input  logic [23:0]        in_imm24,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_instr,
    output logic [31:0]        out_addr,
    output logic               err,
`ifdef UWARM_ENC_HALT_EN
    output logic               halted,
`endif
    output logic [COUNT_W-1:0] word_count
);

    typedef enum logic [3:0] {
        MN_ADD  = 4'd0,
        MN_SUB  = 4'd1,
        MN_AND  = 4'd2,
        MN_ORR  = 4'd3,
        MN_EOR  = 4'd4,
        MN_CMP  = 4'd5,
        MN_LDR  = 4'd6,
        MN_STR  = 4'd7,
        MN_B    = 4'd8,
        MN_HALT = 4'd9
    } mnem_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
    } entry_t;

    function automatic logic [3:0] dp_cmd(input logic [3:0] mnem);
        case (mnem)
            MN_ADD:  return 4'b0100;
            MN_SUB:  return 4'b0010;
            MN_ORR:  return 4'b1100;
            MN_EOR:  return 4'b0001;
            MN_CMP:  return 4'b1010;
            default: return 4'b0000;
        endcase
    endfunction

    logic [1:0]         count_q, count_d;
    entry_t             head_q, head_d, tail_q, tail_d;
    logic [31:0]        next_addr_q, next_addr_d;
    logic               err_q, err_d;
    logic [COUNT_W-1:0] word_count_q, word_count_d;
    logic               halted_q;

    logic [31:0] enc_word;
    logic        enc_legal;
    logic        dp_s;
    logic [3:0]  dp_rd;
    logic [11:0] dp_src2;
    logic        accept, push, pop;
    entry_t      new_entry;

`ifdef UWARM_ENC_HALT_EN
    logic enc_halt;
    logic halted_d;
    assign halted = halted_q;
`else
    assign halted_q = 1'b0;
`endif

    // CMP always updates flags and never writes a destination register.
    assign dp_s    = (in_mnem == MN_CMP) ? 1'b1 : in_s;
    assign dp_rd   = (in_mnem == MN_CMP) ? 4'd0 : in_rd;
    assign dp_src2 = in_imm ? in_imm12 : {8'b0, in_rm};

    // NOTE: every signal driven in always_comb gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b0;
`ifdef UWARM_ENC_HALT_EN
        enc_halt  = 1'b0;
`endif
        case (in_mnem)
            MN_ADD, MN_SUB, MN_AND, MN_ORR, MN_EOR, MN_CMP: begin
                enc_legal = 1'b1;
                enc_word  = {in_cond, 2'b00, in_imm, dp_cmd(in_mnem), dp_s, in_rn, dp_rd, dp_src2};
            end
            MN_LDR, MN_STR: begin
                enc_legal = 1'b1;
                enc_word  = {in_cond, 2'b01, 5'b01100, (in_mnem == MN_LDR), in_rn, in_rd, in_imm12};
            end
            MN_B: begin
                enc_legal = 1'b1;
                enc_word  = {in_cond, 4'b1010, in_imm24};
            end
`ifdef UWARM_ENC_HALT_EN
            MN_HALT: begin
                enc_legal = 1'b1;
                enc_halt  = 1'b1;
                enc_word  = {in_cond, 4'b1010, 24'hFF_FFFE};
            end
`endif
            default: ;
        endcase
    end

    assign in_ready  = (count_q != 2'd2) && !halted_q;
    assign accept    = in_valid && in_ready;
    assign push      = accept && enc_legal;
    assign pop       = out_valid && out_ready;
    assign new_entry = '{instr: enc_word, addr: next_addr_q};

    always_comb begin
        count_d      = count_q;
        head_d       = head_q;
        tail_d       = tail_q;
        next_addr_d  = next_addr_q;
        word_count_d = word_count_q;
        err_d        = err_q | (accept && !enc_legal);
`ifdef UWARM_ENC_HALT_EN
        halted_d     = halted_q | (push && enc_halt);
`endif
        if (push) begin
            next_addr_d  = next_addr_q + 32'd4;
            word_count_d = word_count_q + 1'b1;
        end
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) head_d = new_entry;
                else                 tail_d = new_entry;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    head_d = new_entry;
                end else begin
                    head_d = tail_q;
                    tail_d = new_entry;
                end
            end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the two queue entries are plain flops and are reset so out_instr/out_addr have defined reset values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q      <= 2'd0;
            head_q       <= '{instr: 32'h0, addr: BASE_ADDR};
            tail_q       <= '0;
            next_addr_q  <= BASE_ADDR;
            err_q        <= 1'b0;
            word_count_q <= '0;
`ifdef UWARM_ENC_HALT_EN
            halted_q     <= 1'b0;
`endif
        end else begin
            count_q      <= count_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            next_addr_q  <= next_addr_d;
            err_q        <= err_d;
            word_count_q <= word_count_d;
`ifdef UWARM_ENC_HALT_EN
            halted_q     <= halted_d;
`endif
        end
    end

    assign out_valid  = (count_q != 2'd0);
    assign out_instr  = head_q.instr;
    assign out_addr   = head_q.addr;
    assign err        = err_q;
    assign word_count = word_count_q;

endmodule
